fir_mac_filter: RTL and testbench

Parametrised, time-multiplexed FIR filter: one signed multiply-accumulate per clock over a circular delay line, with run-time loadable coefficients. It replaces the fixed-coefficient 128-tap filter in the signal chain. It adds configurable width, depth, output scaling and saturation, and a valid/ready input handshake with a one-cycle output strobe. The block sits between the sample source (ADC/decimator) and downstream DSP stages.

---
 rtl/fir_mac_filter.sv | 181 ++++++++++++++++++
 tb/tb_fir_mac_filter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_filter.sv
// Time-multiplexed FIR filter: one signed multiply-accumulate per clock over a
// circular delay line, with run-time loadable coefficients, output scaling and
// optional saturation. Samples enter through a valid/ready handshake and each
// result is marked by a one-cycle out_valid strobe.
module fir_mac_filter #(
    parameter int DATA_W   = 18,
    parameter int COEF_W   = 18,
    parameter int TAPS     = 128,
    parameter int ACC_W    = 48,
    parameter int SHIFT    = 8,
    parameter int SATURATE = 1,
    localparam int AW      = $clog2(TAPS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              busy,
    input  logic              coef_we,
    input  logic [AW-1:0]     coef_addr,
    input  logic [COEF_W-1:0] coef_data
);

    localparam int PW = DATA_W + COEF_W;

    // Output range limits, sign-extended to the accumulator width.
    localparam logic signed [ACC_W-1:0] OUT_MAX =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] OUT_MIN =
        {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_OUT
    } state_e;

    state_e                   state_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic [AW-1:0]            k_q;
    logic [AW-1:0]            w_idx_q;
    logic [DATA_W-1:0]        out_data_q;
    logic                     out_valid_q;
    logic                     busy_q;
    logic                     in_ready_q;

    logic signed [DATA_W-1:0] delay_q [TAPS];
    logic signed [COEF_W-1:0] coef_q  [TAPS];

    logic                     accept;
    logic                     coef_wr;
    logic [AW-1:0]            rd_idx;
    logic signed [PW-1:0]     tap_x;
    logic signed [PW-1:0]     tap_c;
    logic signed [PW-1:0]     prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  shifted;
    logic [DATA_W-1:0]        out_data_d;
    logic [AW-1:0]            w_idx_d;

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    // in_ready_q is high only in IDLE, so this is the acceptance condition.
    assign accept  = in_valid && in_ready_q;

    // Coefficient writes are dropped while a sample is being processed so every
    // output sees one consistent coefficient set; out-of-range indices are dropped.
    assign coef_wr = coef_we && !busy_q && (int'(coef_addr) < TAPS);

    // Delay-line read pointer for tap k: (w_idx - k) mod TAPS with explicit wrap,
    // since TAPS need not be a power of two.
    always_comb begin
        if (k_q <= w_idx_q) begin
            rd_idx = w_idx_q - k_q;
        end else begin
            rd_idx = AW'(int'(w_idx_q) + TAPS - int'(k_q));
        end
    end

    // Next write pointer, wrapped by compare rather than masking.
    assign w_idx_d = (w_idx_q == AW'(TAPS - 1)) ? '0 : w_idx_q + AW'(1);

    // Full-precision signed product, sign-extended into the accumulator.
    assign tap_x    = PW'(delay_q[rd_idx]);
    assign tap_c    = PW'(coef_q[k_q]);
    assign prod     = tap_x * tap_c;
    assign prod_ext = ACC_W'(prod);

    assign shifted  = acc_q >>> SHIFT;

    // Output scaling: clamp to the DATA_W range or keep the low DATA_W bits.
    always_comb begin
        // NOTE: assigning a default before any branch keeps this purely
        // combinational; a path that leaves out_data_d unassigned infers a latch.
        out_data_d = shifted[DATA_W-1:0];
        if (SATURATE != 0) begin
            if (shifted > OUT_MAX) begin
                out_data_d = OUT_MAX[DATA_W-1:0];
            end else if (shifted < OUT_MIN) begin
                out_data_d = OUT_MIN[DATA_W-1:0];
            end
        end
    end

    // Control FSM (IDLE -> MAC -> OUT -> IDLE) with registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            k_q         <= '0;
            w_idx_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        acc_q      <= '0;
                        k_q        <= '0;
                        state_q    <= S_MAC;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                S_MAC: begin
                    acc_q <= acc_q + prod_ext;
                    if (k_q == AW'(TAPS - 1)) begin
                        state_q <= S_OUT;
                    end else begin
                        k_q <= k_q + AW'(1);
                    end
                end
                S_OUT: begin
                    w_idx_q     <= w_idx_d;
                    out_data_q  <= out_data_d;
                    out_valid_q <= 1'b1;
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                end
                default: begin
                    state_q    <= S_IDLE;
                    in_ready_q <= 1'b1;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    // Delay line and coefficient bank: sample write on acceptance, coefficient
    // write when idle; both are cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: these arrays must read as zero straight after reset, so they are
        // built as resettable flops; a RAM macro could not be cleared this way.
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) begin
                delay_q[i] <= '0;
                coef_q[i]  <= '0;
            end
        end else begin
            if (accept) begin
                delay_q[w_idx_q] <= $signed(in_data);
            end
            if (coef_wr) begin
                coef_q[coef_addr] <= $signed(coef_data);
            end
        end
    end

endmodule

// File: tb/tb_fir_mac_filter.sv
// Self-checking bench for fir_mac_filter. Two instances share all inputs and
// differ only in SATURATE. A driver issues samples and coefficient writes and
// pushes expected results, computed from a sample-history model, into queues;
// a monitor compares every cycle against those queues and the expected
// handshake timing. TAPS=12 exercises non-power-of-two wrapping.
module tb_fir_mac_filter;

    localparam int DATA_W = 18;
    localparam int COEF_W = 18;
    localparam int TAPS   = 12;
    localparam int ACC_W  = 48;
    localparam int SHIFT  = 2;
    localparam int AW     = $clog2(TAPS);
    localparam int PERIOD = 10;
    localparam longint OUT_MAX = (longint'(1) <<< (DATA_W - 1)) - 1;
    localparam longint OUT_MIN = -(longint'(1) <<< (DATA_W - 1));

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_valid = 1'b0;
    logic              coef_we = 1'b0;
    logic [AW-1:0]     coef_addr = '0;
    logic [COEF_W-1:0] coef_data = '0;

    logic              in_ready_s, out_valid_s, busy_s;
    logic [DATA_W-1:0] out_data_s;
    logic              in_ready_t, out_valid_t, busy_t;
    logic [DATA_W-1:0] out_data_t;

    int     total = 0;
    int     bad = 0;
    int     cyc = 0;
    longint mcoef [TAPS];
    longint hist [$];
    longint q_sat [$];
    longint q_trn [$];
    int     q_cyc [$];
    int     last_accept = -1000;
    longint held_sat = 0;
    longint held_trn = 0;

    fir_mac_filter #(
        .DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS),
        .ACC_W(ACC_W), .SHIFT(SHIFT), .SATURATE(1)
    ) u_dut_sat (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_s),
        .out_data(out_data_s), .out_valid(out_valid_s), .busy(busy_s),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data)
    );

    fir_mac_filter #(
        .DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS),
        .ACC_W(ACC_W), .SHIFT(SHIFT), .SATURATE(0)
    ) u_dut_trn (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_t),
        .out_data(out_data_t), .out_valid(out_valid_t), .busy(busy_t),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data)
    );

    always #(PERIOD / 2) clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Busy window implied by the most recent acceptance seen at cycle c0:
    // cycles c0+1 .. c0+TAPS+1 (MAC plus OUT).
    function automatic bit exp_busy_at(int c);
        return (c >= last_accept + 1) && (c <= last_accept + TAPS + 1);
    endfunction

    function automatic longint wrap_acc(longint a);
        return (a <<< (64 - ACC_W)) >>> (64 - ACC_W);
    endfunction

    function automatic longint scale_sat(longint acc);
        longint s = acc >>> SHIFT;
        if (s > OUT_MAX) return OUT_MAX;
        if (s < OUT_MIN) return OUT_MIN;
        return s;
    endfunction

    function automatic longint scale_trn(longint acc);
        longint s = acc >>> SHIFT;
        return (s <<< (64 - DATA_W)) >>> (64 - DATA_W);
    endfunction

    // Convolution over the sample history; samples older than reset count as 0.
    function automatic longint model_acc();
        longint a = 0;
        int n = hist.size();
        for (int k = 0; k < TAPS; k++) begin
            if (n - 1 - k >= 0) a += mcoef[k] * hist[n - 1 - k];
        end
        return wrap_acc(a);
    endfunction

    task automatic apply_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        coef_we  = 1'b0;
        hist.delete();
        q_sat.delete();
        q_trn.delete();
        q_cyc.delete();
        foreach (mcoef[i]) mcoef[i] = 0;
        last_accept = -1000;
        held_sat    = 0;
        held_trn    = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic write_coef(input int addr, input longint val);
        coef_we   = 1'b1;
        coef_addr = AW'(addr);
        coef_data = COEF_W'(val);
        if (!exp_busy_at(cyc) && addr < TAPS) mcoef[addr] = val;
        @(negedge clk);
        coef_we = 1'b0;
    endtask

    // Present a sample until accepted; optionally issue a coefficient write in
    // the acceptance cycle. Returns the cycle number seen at acceptance.
    task automatic send(input longint x, input bit hold, input bit wr,
                        input int waddr, input longint wval, output int acc_c);
        int waited = 0;
        acc_c    = -1;
        in_data  = DATA_W'(x);
        in_valid = 1'b1;
        while (!in_ready_s && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready_s) begin
            check("in_ready_timeout", in_ready_s, 1);
            in_valid = 1'b0;
            return;
        end
        if (wr) begin
            coef_we   = 1'b1;
            coef_addr = AW'(waddr);
            coef_data = COEF_W'(wval);
            if (waddr < TAPS) mcoef[waddr] = wval;
        end
        hist.push_back(x);
        begin
            longint a = model_acc();
            q_sat.push_back(scale_sat(a));
            q_trn.push_back(scale_trn(a));
        end
        q_cyc.push_back(cyc + TAPS + 2);
        last_accept = cyc;
        acc_c = cyc;
        @(negedge clk);
        coef_we = 1'b0;
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic send1(input longint x);
        int c;
        send(x, 1'b0, 1'b0, 0, 0, c);
    endtask

    // Monitor: handshake status, strobe timing and held output data, every cycle.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            begin
                bit eb;
                bit ev;
                eb = rst_n && exp_busy_at(cyc);
                ev = rst_n && (q_cyc.size() > 0) && (q_cyc[0] == cyc);
                check("busy_sat", busy_s, eb);
                check("busy_trn", busy_t, eb);
                check("in_ready_sat", in_ready_s, !eb);
                check("in_ready_trn", in_ready_t, !eb);
                check("out_valid_sat", out_valid_s, ev);
                check("out_valid_trn", out_valid_t, ev);
                if (ev) begin
                    held_sat = q_sat.pop_front();
                    held_trn = q_trn.pop_front();
                    void'(q_cyc.pop_front());
                end
                check("out_data_sat", $signed(out_data_s), held_sat);
                check("out_data_trn", $signed(out_data_t), held_trn);
            end
        end
    end

    initial begin
        #(PERIOD * 200000);
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int     acc_c;
        int     prev_c;
        longint x;

        #1;
        apply_reset();

        // Impulse response: coef[k]=k+1 for k<8; 400>>>2 scaling gives 100..800,
        // then zeros once the impulse leaves the nonzero taps, then a second
        // impulse after the write pointer has wrapped.
        for (int k = 0; k < 8; k++) write_coef(k, k + 1);
        send1(400);
        for (int i = 0; i < 11; i++) send1(0);
        send1(-400);
        for (int i = 0; i < 3; i++) send1(0);

        // Saturation, positive then negative full-scale.
        apply_reset();
        for (int k = 0; k < TAPS; k++) write_coef(k, 131071);
        for (int i = 0; i < 4; i++) send1(131071);
        apply_reset();
        for (int k = 0; k < TAPS; k++) write_coef(k, 131071);
        for (int i = 0; i < 4; i++) send1(-131072);

        // Throughput with in_valid held high and random data/coefficients.
        apply_reset();
        for (int k = 0; k < TAPS; k++) write_coef(k, longint'(int'($urandom_range(0, 128)) - 64));
        prev_c = 0;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 1) == 1)
                x = longint'(int'($urandom_range(0, 262143)) - 131072);
            else
                x = longint'(int'($urandom_range(0, 2047)) - 1024);
            send(x, 1'b1, 1'b0, 0, 0, acc_c);
            if (i > 0) check("accept_interval", acc_c - prev_c, TAPS + 2);
            prev_c = acc_c;
        end
        in_valid = 1'b0;

        // Coefficient writes while busy are dropped; idle writes take effect.
        apply_reset();
        for (int k = 0; k < TAPS; k++) write_coef(k, k + 1);
        send1(1000);
        repeat (3) @(negedge clk);
        write_coef(0, 999);
        send1(500);
        send1(-700);
        repeat (TAPS + 2) @(negedge clk);
        write_coef(0, 999);
        write_coef(13, 777);
        send1(300);
        send(200, 1'b0, 1'b1, 1, -5000, acc_c);
        repeat (TAPS) @(negedge clk);
        write_coef(2, 4321);
        send1(-250);
        send1(90);

        // Reset in the fifth MAC cycle discards the sample and clears coefficients.
        apply_reset();
        for (int k = 0; k < TAPS; k++) write_coef(k, k + 1);
        send1(400);
        repeat (4) @(negedge clk);
        apply_reset();
        send1(400);
        send1(123);

        for (int i = 0; i < 200 && q_cyc.size() > 0; i++) @(negedge clk);
        check("pending_outputs", q_cyc.size(), 0);
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
